// File: rtl/cond_pkg.sv
// Shared types and constants for the conditional-execution stage.
package cond_pkg;

  typedef enum logic [3:0] {
    EQ = 4'b0000, NE = 4'b0001, CS = 4'b0010, CC = 4'b0011,
    MI = 4'b0100, PL = 4'b0101, VS = 4'b0110, VC = 4'b0111,
    HI = 4'b1000, LS = 4'b1001, GE = 4'b1010, LT = 4'b1011,
    GT = 4'b1100, LE = 4'b1101, AL = 4'b1110, NV = 4'b1111
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // FlagW bit selecting each flag group
  localparam int FLAGW_NZ = 1;
  localparam int FLAGW_CV = 0;

endpackage

// File: rtl/cond_check.sv
// Combinational condition evaluator: 4-bit condition field against {N,Z,C,V}.
module cond_check
  import cond_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;
  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    pass = 1'b0;
    case (cond_e'(cond))
      EQ: pass = z;
      NE: pass = ~z;
      CS: pass = c;
      CC: pass = ~c;
      MI: pass = n;
      PL: pass = ~n;
      VS: pass = v;
      VC: pass = ~v;
      HI: pass = c & ~z;
      LS: pass = ~c | z;
      GE: pass = (n == v);
      LT: pass = (n != v);
      GT: pass = ~z & (n == v);
      LE: pass = z | (n != v);
      AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// Conditional-execution stage: NZCV register, condition gating of write strobes.
// Define COND_PERF_CNT_EN to add executed/squashed instruction counters.
module cond_unit
  import cond_pkg::*;
#(
  parameter int CNT_W = 32
)
(
  input  logic             clk,
  input  logic             reset,
  input  logic             InstrValid,
  input  logic [3:0]       Cond,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       FlagW,
  input  logic             PCS,
  input  logic             RegW,
  input  logic             MemW,
  input  logic             NoWrite,
  output logic             CondEx,
  output logic             PCSrc,
  output logic             RegWrite,
  output logic             MemWrite,
`ifdef COND_PERF_CNT_EN
  output logic [CNT_W-1:0] ExecCnt,
  output logic [CNT_W-1:0] SquashCnt,
`endif
  output logic [3:0]       Flags
);

  logic [3:0] flags_q;
  logic       pass;
  logic       wr_nz, wr_cv;

  cond_check u_chk (
    .cond  (Cond),
    .flags (flags_q),
    .pass  (pass)
  );

  assign CondEx   = InstrValid & pass;
  assign PCSrc    = PCS & CondEx;
  assign RegWrite = RegW & CondEx & ~NoWrite;
  assign MemWrite = MemW & CondEx;
  assign Flags    = flags_q;

  assign wr_nz = CondEx & FlagW[FLAGW_NZ];
  assign wr_cv = CondEx & FlagW[FLAGW_CV];

  // Only enabled groups are sampled, so an X on an unselected ALU flag never lands here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q <= 4'b0000;
    end else begin
      if (wr_nz) flags_q[FLAG_N:FLAG_Z] <= ALUFlags[FLAG_N:FLAG_Z];
      if (wr_cv) flags_q[FLAG_C:FLAG_V] <= ALUFlags[FLAG_C:FLAG_V];
    end
  end

`ifdef COND_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ExecCnt   <= '0;
      SquashCnt <= '0;
    end else if (InstrValid) begin
      if (CondEx) ExecCnt   <= ExecCnt + 1'b1;
      else        SquashCnt <= SquashCnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_cond_unit.sv
// Directed self-checking bench for cond_unit (counter checks when COND_PERF_CNT_EN is defined).
module tb_cond_unit;

  logic       clk, reset;
  logic       InstrValid;
  logic [3:0] Cond, ALUFlags;
  logic [1:0] FlagW;
  logic       PCS, RegW, MemW, NoWrite;
  logic       CondEx, PCSrc, RegWrite, MemWrite;
  logic [3:0] Flags;
`ifdef COND_PERF_CNT_EN
  logic [3:0] ExecCnt, SquashCnt;
`endif

  int checks = 0;
  int errors = 0;

  cond_unit #(.CNT_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .InstrValid (InstrValid),
    .Cond       (Cond),
    .ALUFlags   (ALUFlags),
    .FlagW      (FlagW),
    .PCS        (PCS),
    .RegW       (RegW),
    .MemW       (MemW),
    .NoWrite    (NoWrite),
    .CondEx     (CondEx),
    .PCSrc      (PCSrc),
    .RegWrite   (RegWrite),
    .MemWrite   (MemWrite),
`ifdef COND_PERF_CNT_EN
    .ExecCnt    (ExecCnt),
    .SquashCnt  (SquashCnt),
`endif
    .Flags      (Flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // one AL instruction writing both flag groups
  task automatic set_flags(input logic [3:0] f);
    InstrValid = 1'b1; Cond = 4'b1110; ALUFlags = f; FlagW = 2'b11;
    step();
    FlagW = 2'b00;
  endtask

  // {cond, flags, expected pass}
  logic [8:0] cvec [10] = '{
    {4'b1000, 4'b0110, 1'b0},  // HI with Z=1
    {4'b1001, 4'b0110, 1'b1},  // LS
    {4'b0010, 4'b0110, 1'b1},  // CS
    {4'b0011, 4'b0110, 1'b0},  // CC
    {4'b1111, 4'b1111, 1'b0},  // NV never
    {4'b0100, 4'b1000, 1'b1},  // MI
    {4'b0101, 4'b1000, 1'b0},  // PL
    {4'b0110, 4'b0001, 1'b1},  // VS
    {4'b0111, 4'b0001, 1'b0},  // VC
    {4'b1100, 4'b1001, 1'b1}   // GT with N==V, Z=0
  };

  initial begin
    reset = 1'b1; InstrValid = 1'b0; Cond = 4'b0000; ALUFlags = 4'b0000;
    FlagW = 2'b00; PCS = 1'b0; RegW = 1'b0; MemW = 1'b0; NoWrite = 1'b0;
    step(); step();
    chk("reset_flags", 32'(Flags), 32'h0);
    reset = 1'b0;

    // async reset from 1111 mid-cycle
    set_flags(4'b1111);
    chk("flags_1111", 32'(Flags), 32'hf);
    #2 reset = 1'b1;
    #1 chk("async_reset_flags", 32'(Flags), 32'h0);
    Cond = 4'b0000;
    #1 chk("reset_eq_fail", 32'(CondEx), 32'h0);
    Cond = 4'b1110;
    #1 chk("reset_al_pass", 32'(CondEx), 32'h1);
    step();
    reset = 1'b0;

    // SUBS with zero result
    set_flags(4'b0110);
    chk("subs_flags", 32'(Flags), 32'h6);
    RegW = 1'b1; Cond = 4'b0000;
    #1 chk("eq_regwrite", 32'(RegWrite), 32'h1);
    Cond = 4'b0001;
    #1 chk("ne_regwrite", 32'(RegWrite), 32'h0);
    RegW = 1'b0;

    // ANDS writes only N,Z; V input is X
    set_flags(4'b0011);
    chk("pre_ands_flags", 32'(Flags), 32'h3);
    Cond = 4'b1110; ALUFlags = 4'b100x; FlagW = 2'b10;
    step();
    FlagW = 2'b00;
    chk("ands_flags", 32'(Flags), 32'hb);

    // same-cycle write uses old flags: Z=0 so EQ fails even though ALU says Z=1
    set_flags(4'b0000);
    Cond = 4'b0000; ALUFlags = 4'b1111; FlagW = 2'b11; MemW = 1'b1;
    #1 chk("squash_memwrite", 32'(MemWrite), 32'h0);
    chk("squash_condex", 32'(CondEx), 32'h0);
    step();
    FlagW = 2'b00; MemW = 1'b0;
    chk("squash_flags", 32'(Flags), 32'h0);

    // signed compares with N=1, V=0
    set_flags(4'b1000);
    Cond = 4'b1011; #1 chk("lt_pass", 32'(CondEx), 32'h1);
    Cond = 4'b1010; #1 chk("ge_fail", 32'(CondEx), 32'h0);
    Cond = 4'b1100; #1 chk("gt_fail", 32'(CondEx), 32'h0);
    Cond = 4'b1101; #1 chk("le_pass", 32'(CondEx), 32'h1);
    Cond = 4'b1110; RegW = 1'b1; NoWrite = 1'b1;
    #1 chk("cmp_regwrite", 32'(RegWrite), 32'h0);
    chk("cmp_condex", 32'(CondEx), 32'h1);
    RegW = 1'b0; NoWrite = 1'b0;

    // branch strobe, valid vs bubble
    PCS = 1'b1;
    #1 chk("pcsrc_valid", 32'(PCSrc), 32'h1);
    InstrValid = 1'b0; RegW = 1'b1; MemW = 1'b1;
    #1 chk("bubble_pcsrc", 32'(PCSrc), 32'h0);
    chk("bubble_regwrite", 32'(RegWrite), 32'h0);
    chk("bubble_memwrite", 32'(MemWrite), 32'h0);
    chk("bubble_condex", 32'(CondEx), 32'h0);
    PCS = 1'b0; RegW = 1'b0; MemW = 1'b0;

    // condition table sweep
    foreach (cvec[i]) begin
      set_flags(cvec[i][4:1]);
      Cond = cvec[i][8:5];
      #1 chk($sformatf("cond_%b_flags_%b", cvec[i][8:5], cvec[i][4:1]), 32'(CondEx), 32'(cvec[i][0]));
    end

`ifdef COND_PERF_CNT_EN
    InstrValid = 1'b0; FlagW = 2'b00;
    reset = 1'b1; #2 reset = 1'b0;
    chk("cnt_reset_exec", 32'(ExecCnt), 32'h0);
    chk("cnt_reset_squash", 32'(SquashCnt), 32'h0);
    InstrValid = 1'b1; Cond = 4'b1110; step();
    Cond = 4'b1111; step();
    InstrValid = 1'b0; step();
    InstrValid = 1'b1; Cond = 4'b1110; step();
    Cond = 4'b1111; step();
    InstrValid = 1'b0; step();
    InstrValid = 1'b1; Cond = 4'b1110; step();
    InstrValid = 1'b0;
    chk("exec_cnt", 32'(ExecCnt), 32'h3);
    chk("squash_cnt", 32'(SquashCnt), 32'h2);
    InstrValid = 1'b1; Cond = 4'b1110;
    for (int i = 0; i < 12; i++) step();
    chk("exec_cnt_max", 32'(ExecCnt), 32'hf);
    step();
    chk("exec_cnt_wrap", 32'(ExecCnt), 32'h0);
    chk("squash_cnt_hold", 32'(SquashCnt), 32'h2);
    InstrValid = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cond_unit.md
# cond_unit

Conditional-execution stage sitting directly downstream of the ALU in the single-cycle ARM-subset datapath. It holds the architectural NZCV flags register, updates it from the ALU's `ALUFlags` output under per-group write enables, and evaluates the instruction's 4-bit condition field against the stored flags. It gates the controller's `PCS`/`RegW`/`MemW` into the final `PCSrc`/`RegWrite`/`MemWrite` strobes, and optionally counts executed vs. squashed instructions.

## Interface
Parameters:
- CNT_W, 32, width of the performance counters (compiled in only with the macro)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- InstrValid  in  1  current instruction is real; 0 is a bubble
- Cond  in  4  instruction condition field, bits [31:28]
- ALUFlags  in  4  {N,Z,C,V} from the ALU, same cycle
- FlagW  in  2  [1] writes N,Z; [0] writes C,V
- PCS  in  1  instruction writes PC
- RegW  in  1  instruction writes register file
- MemW  in  1  instruction writes memory
- NoWrite  in  1  compare-type op (CMP/TST): suppress RegWrite
- CondEx  out  1  condition passed for a valid instruction
- PCSrc  out  1  PCS & CondEx
- RegWrite  out  1  RegW & CondEx & ~NoWrite
- MemWrite  out  1  MemW & CondEx
- Flags  out  4  stored {N,Z,C,V}
- ExecCnt  out  CNT_W  executed-instruction count (macro only)
- SquashCnt  out  CNT_W  squashed-instruction count (macro only)

## Operation
- Flag bit order: [3]=N, [2]=Z, [1]=C, [0]=V, matching ALUFlags.
- Condition evaluated on stored Flags (pre-update): 0000 EQ Z; 0001 NE ~Z; 0010 CS C; 0011 CC ~C; 0100 MI N; 0101 PL ~N; 0110 VS V; 0111 VC ~V; 1000 HI C&~Z; 1001 LS ~C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT ~Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 reserved, 0.
- CondEx = InstrValid & condition result; all three output strobes are 0 when InstrValid=0.
- Flag update at clock edge: if CondEx & FlagW[1], {N,Z} <= ALUFlags[3:2]; if CondEx & FlagW[0], {C,V} <= ALUFlags[1:0]. Non-enabled bits hold.
- ALUFlags bits not selected by FlagW may be X (ALU drives V=X on logical/shift ops); they must never reach Flags.
- Squashed instruction (InstrValid=1, condition fails) changes no flags and asserts no strobe.

## Timing
- Strobes and CondEx: combinational from inputs and registered Flags, zero latency.
- Flags: one-cycle latency; an instruction following a flag-setting instruction sees new flags next cycle.
- Reset (async assert, any time including mid-instruction): Flags=4'b0000, ExecCnt=0, SquashCnt=0 immediately; strobes follow from inputs (EQ fails, AL passes).
- Same-cycle flag write and condition check: check uses old value; no bypass.
- Counters: on each edge with InstrValid=1, ExecCnt+=1 if CondEx else SquashCnt+=1; wrap modulo 2^CNT_W, no saturation.

## Configuration
- COND_PERF_CNT_EN defined: ExecCnt/SquashCnt ports and registers present.
- Undefined: counter ports and logic removed; remaining behaviour identical.

## Structure
- cond_pkg: cond_e enum (EQ..AL, NV=4'b1111), flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0, flag group FlagW bit constants.
- Sub-module cond_check: purely combinational Cond x Flags -> pass; cond_unit holds registers, gating, and counters.

## Test plan
- Reset with Flags previously 1111 -> Flags=0000 asynchronously; Cond=0000 gives CondEx=0, Cond=1110 gives CondEx=1.
- SUBS result zero: ALUFlags=0110, FlagW=11, Cond=1110 -> next cycle Flags=0110; Cond=0000 with RegW=1 gives RegWrite=1, Cond=0001 gives RegWrite=0.
- ANDS with ALUFlags=100x, FlagW=10 from Flags=0011 -> Flags=1011; V stays 1, no X.
- Squash: Flags=0000, Cond=0000, FlagW=11, ALUFlags=1111, MemW=1 -> MemWrite=0, Flags unchanged 0000.
- Signed compares: Flags N=1,V=0 -> LT pass, GE fail, GT fail, LE pass; CMP with NoWrite=1,RegW=1,Cond=1110 -> RegWrite=0.
- COND_PERF_CNT_EN: 5 valid instructions (3 pass, 2 fail) plus 2 bubbles -> ExecCnt=3, SquashCnt=2; preload via reset-free run to 2^CNT_W-1 with CNT_W=4, one more pass -> ExecCnt=0.
